// File: rtl/ram_ctrl_pkg.sv
// Shared types and default sizes for the program RAM controller.
package ram_ctrl_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 4;
    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        CPU_RUN,
        MAN_IDLE,
        MAN_WRITE,
        CLEAR
    } state_t;

endpackage

// File: rtl/button_edge_detect.sv
// Rising-edge detector for a vector of already-synchronised buttons.
module button_edge_detect #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] btn,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] btn_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_q <= '0;
        end else begin
            btn_q <= btn;
        end
    end

    assign rise = btn & ~btn_q;

endmodule

// File: rtl/ram_program_controller.sv
// Arbitrates the program RAM between the CPU and the front-panel programmer.
module ram_program_controller
    import ram_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int                    DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  manual_mode,
    input  logic                  cpu_boundary,
    input  logic                  btn_write,
    input  logic                  btn_set_addr,
    input  logic                  btn_clear,
    input  logic [ADDR_WIDTH-1:0] addr_switches,
    input  logic [DATA_WIDTH-1:0] prog_switches,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic                  cpu_write,
    input  logic [DATA_WIDTH-1:0] cpu_data,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_write,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  cpu_stall,
    output logic [ADDR_WIDTH-1:0] prog_address,
    output logic                  busy
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] prog_address_q, prog_address_d;
    logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [2:0]            btn_rise;
    logic                  ev_write, ev_set_addr, ev_clear;

    button_edge_detect #(.WIDTH(3)) u_edges (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   ({btn_clear, btn_set_addr, btn_write}),
        .rise  (btn_rise)
    );

    assign ev_write    = btn_rise[0];
    assign ev_set_addr = btn_rise[1];
    assign ev_clear    = btn_rise[2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= CPU_RUN;
            prog_address_q <= '0;
            sweep_q        <= '0;
            wdata_q        <= '0;
        end else begin
            state_q        <= state_d;
            prog_address_q <= prog_address_d;
            sweep_q        <= sweep_d;
            wdata_q        <= wdata_d;
        end
    end

    // Event priority in MAN_IDLE is clear > set_addr > write; only the winner acts.
    always_comb begin
        state_d        = state_q;
        prog_address_d = prog_address_q;
        sweep_d        = sweep_q;
        wdata_d        = wdata_q;
        ram_address    = cpu_address;
        ram_write      = cpu_write;
        ram_wdata      = cpu_data;
        case (state_q)
            CPU_RUN: begin
                if (manual_mode && cpu_boundary) begin
                    state_d = MAN_IDLE;
                end
            end
            MAN_IDLE: begin
                ram_address = prog_address_q;
                ram_wdata   = prog_switches;
                ram_write   = 1'b0;
                if (ev_clear) begin
                    sweep_d = '0;
                    state_d = CLEAR;
                end else if (ev_set_addr) begin
                    prog_address_d = addr_switches;
                end else if (ev_write) begin
                    wdata_d = prog_switches;
                    state_d = MAN_WRITE;
                end else if (!manual_mode) begin
                    state_d = CPU_RUN;
                end
            end
            MAN_WRITE: begin
                ram_address    = prog_address_q;
                ram_wdata      = wdata_q;
                ram_write      = 1'b1;
                prog_address_d = prog_address_q + 1'b1;
                state_d        = MAN_IDLE;
            end
            CLEAR: begin
                ram_address = sweep_q;
                ram_wdata   = CLEAR_VALUE;
                ram_write   = 1'b1;
                sweep_d     = sweep_q + 1'b1;
                if (sweep_q == {ADDR_WIDTH{1'b1}}) begin
                    prog_address_d = '0;
                    state_d        = MAN_IDLE;
                end
            end
            default: begin
                state_d = CPU_RUN;
            end
        endcase
    end

    assign cpu_stall    = (state_q != CPU_RUN);
    assign busy         = (state_q == MAN_WRITE) || (state_q == CLEAR);
    assign prog_address = prog_address_q;

endmodule

// File: tb/tb_ram_program_controller.sv
// Directed self-checking bench for ram_program_controller with a behavioural RAM.
module tb_ram_program_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       manual_mode, cpu_boundary;
    logic       btn_write, btn_set_addr, btn_clear;
    logic [3:0] addr_switches, cpu_address;
    logic [7:0] prog_switches, cpu_data;
    logic       cpu_write;
    logic [3:0] ram_address, prog_address;
    logic       ram_write, cpu_stall, busy;
    logic [7:0] ram_wdata;

    logic [7:0] mem [16];
    int         wr_count;
    logic       cnt_clear;
    int         total = 0;
    int         bad   = 0;

    ram_program_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .manual_mode   (manual_mode),
        .cpu_boundary  (cpu_boundary),
        .btn_write     (btn_write),
        .btn_set_addr  (btn_set_addr),
        .btn_clear     (btn_clear),
        .addr_switches (addr_switches),
        .prog_switches (prog_switches),
        .cpu_address   (cpu_address),
        .cpu_write     (cpu_write),
        .cpu_data      (cpu_data),
        .ram_address   (ram_address),
        .ram_write     (ram_write),
        .ram_wdata     (ram_wdata),
        .cpu_stall     (cpu_stall),
        .prog_address  (prog_address),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for random_access_memory plus a write counter.
    always @(posedge clk) begin
        if (ram_write) mem[ram_address] <= ram_wdata;
        if (cnt_clear) wr_count <= 0;
        else if (ram_write) wr_count <= wr_count + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic s, input logic c);
        @(negedge clk);
        btn_write    = w;
        btn_set_addr = s;
        btn_clear    = c;
    endtask

    initial begin
        rst_n = 1'b0; manual_mode = 1'b0; cpu_boundary = 1'b0;
        btn_write = 1'b0; btn_set_addr = 1'b0; btn_clear = 1'b0;
        addr_switches = 4'd0; prog_switches = 8'd0;
        cpu_address = 4'd3; cpu_data = 8'h77; cpu_write = 1'b1; cnt_clear = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_stall", cpu_stall, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_prog", prog_address, 0);
        checkOutput("rst_passthru_we", ram_write, 1);
        checkOutput("rst_passthru_addr", ram_address, 3);
        @(negedge clk);
        rst_n = 1'b1; cpu_write = 1'b0; cnt_clear = 1'b0;

        // 1: CPU write pass-through
        @(negedge clk);
        cpu_write = 1'b1; cpu_address = 4'd5; cpu_data = 8'h2A;
        #1;
        checkOutput("t1_we", ram_write, 1);
        checkOutput("t1_addr", ram_address, 5);
        @(negedge clk);
        cpu_write = 1'b0;
        #1;
        checkOutput("t1_mem5", mem[5], 8'h2A);
        checkOutput("t1_stall", cpu_stall, 0);

        // 2: manual request waits for the instruction boundary
        manual_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cpu_write = 1'b1; cpu_address = 4'(i + 1); cpu_data = 8'(8'h40 + i);
            #1;
            checkOutput("t2_no_stall", cpu_stall, 0);
        end
        @(negedge clk);
        cpu_boundary = 1'b1; cpu_address = 4'd4; cpu_data = 8'h43;
        #1;
        checkOutput("t2_boundary_stall", cpu_stall, 0);
        checkOutput("t2_boundary_we", ram_write, 1);
        @(negedge clk);
        cpu_boundary = 1'b0; cpu_write = 1'b0;
        #1;
        checkOutput("t2_stall_up", cpu_stall, 1);
        checkOutput("t2_idle_we", ram_write, 0);
        for (int i = 0; i < 4; i++) checkOutput("t2_mem", mem[i + 1], 8'h40 + i);

        // 3: set address then three writes with wrap
        addr_switches = 4'd14;
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("t3_setaddr", prog_address, 14);
        prog_switches = 8'h11;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("t3_busy", busy, 1);
        checkOutput("t3_wr_we", ram_write, 1);
        checkOutput("t3_wr_addr", ram_address, 14);
        checkOutput("t3_wr_data", ram_wdata, 8'h11);
        prog_switches = 8'h22;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        prog_switches = 8'h33;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("t3_mem14", mem[14], 8'h11);
        checkOutput("t3_mem15", mem[15], 8'h22);
        checkOutput("t3_mem0", mem[0], 8'h33);
        checkOutput("t3_prog", prog_address, 1);

        // 4: held write button acts once
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0; prog_switches = 8'h55; btn_write = 1'b1;
        repeat (10) @(negedge clk);
        btn_write = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("t4_count", wr_count, 1);
        checkOutput("t4_prog", prog_address, 2);
        checkOutput("t4_mem1", mem[1], 8'h55);

        // 5: simultaneous events, clear wins; manual_mode drop deferred
        cnt_clear = 1'b1; addr_switches = 4'd9;
        @(negedge clk);
        cnt_clear = 1'b0;
        btn_write = 1'b1; btn_set_addr = 1'b1; btn_clear = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            #1;
            checkOutput("t5_sweep_addr", ram_address, i);
            checkOutput("t5_sweep_busy", busy, 1);
            if (i == 3) manual_mode = 1'b0;
            @(negedge clk);
        end
        #1;
        checkOutput("t5_count", wr_count, 16);
        checkOutput("t5_prog", prog_address, 0);
        checkOutput("t5_still_stalled", cpu_stall, 1);
        checkOutput("t5_idle_busy", busy, 0);
        @(negedge clk);
        #1;
        checkOutput("t5_released", cpu_stall, 0);
        for (int i = 0; i < 16; i++) checkOutput("t5_mem_zero", mem[i], 8'h00);

        // 6: reset in the middle of a sweep
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cpu_write = 1'b1; cpu_address = 4'(i); cpu_data = 8'(8'hA0 + i);
        end
        @(negedge clk);
        cpu_write = 1'b0; manual_mode = 1'b1; cpu_boundary = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1);
        cpu_boundary = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        #1;
        checkOutput("t6_sweep7", ram_address, 7);
        rst_n = 1'b0; manual_mode = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("t6_stall", cpu_stall, 0);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_prog", prog_address, 0);
        for (int i = 0; i < 7; i++) checkOutput("t6_mem_cleared", mem[i], 8'h00);
        for (int i = 8; i < 16; i++) checkOutput("t6_mem_kept", mem[i], 8'hA0 + i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
